// File: rtl/uart_rx_top_if.sv
// Receiver-side bundle: serial line and frame config in, recovered byte and per-frame status out.
// No backpressure; every result is a one-cycle pulse the consumer must catch.
interface uart_rx_top_if;
    logic       rx_in;
    logic       parity_en;
    logic       parity_type;
    logic [7:0] data_out;
    logic       data_valid;
    logic       parity_error;
    logic       stop_error;
    logic       busy;

    modport slave (
        input  rx_in,
        input  parity_en,
        input  parity_type,
        output data_out,
        output data_valid,
        output parity_error,
        output stop_error,
        output busy
    );

    modport master (
        output rx_in,
        output parity_en,
        output parity_type,
        input  data_out,
        input  data_valid,
        input  parity_error,
        input  stop_error,
        input  busy
    );
endinterface

// File: rtl/uart_rx_top.sv
// UART receiver: oversampled majority-vote bit recovery, 8N1 or 8 with parity plus 1 stop bit.
// Result pulses appear 2 + (10 or 11)*PRESCALE cycles after the start edge; no backpressure.
module uart_rx_top #(
    parameter int PRESCALE = 8
) (
    input  logic          clk,
    input  logic          rst,
    uart_rx_top_if.slave  bus
);
    localparam int EW = $clog2(PRESCALE);
    localparam logic [EW-1:0] EDGE_LAST = EW'(PRESCALE - 1);
    localparam logic [EW-1:0] EDGE_S0   = EW'(PRESCALE / 2 - 1);
    localparam logic [EW-1:0] EDGE_S1   = EW'(PRESCALE / 2);
    localparam logic [EW-1:0] EDGE_S2   = EW'(PRESCALE / 2 + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    logic          sync1_q, sync2_q;
    state_t        state_q, state_d;
    logic [EW-1:0] edge_q, edge_d;
    logic [2:0]    bit_q, bit_d;
    logic [1:0]    smp_q, smp_d;
    logic [7:0]    shift_q, shift_d;
    logic          pen_q, pen_d;
    logic          ptype_q, ptype_d;
    logic          perr_q, perr_d;
    logic          serr_q, serr_d;
    logic [7:0]    data_q, data_d;
    logic          dv_q, dv_d;
    logic          pe_q, pe_d;
    logic          se_q, se_d;

    logic          rx_s;
    logic          maj;
    logic          edge_last;
    logic          at_vote;

    assign rx_s      = sync2_q;
    assign edge_last = (edge_q == EDGE_LAST);
    assign at_vote   = (edge_q == EDGE_S2);
    // Third sample is taken live from rx_s so the vote is usable in the same cycle.
    assign maj       = (smp_q[0] & smp_q[1]) | (smp_q[0] & rx_s) | (smp_q[1] & rx_s);

    always_comb begin
        state_d = state_q;
        edge_d  = edge_q;
        bit_d   = bit_q;
        smp_d   = smp_q;
        shift_d = shift_q;
        pen_d   = pen_q;
        ptype_d = ptype_q;
        perr_d  = perr_q;
        serr_d  = serr_q;
        data_d  = data_q;
        dv_d    = 1'b0;
        pe_d    = 1'b0;
        se_d    = 1'b0;

        if (state_q != S_IDLE) begin
            edge_d = edge_last ? '0 : edge_q + EW'(1);
            if (edge_q == EDGE_S0) smp_d[0] = rx_s;
            if (edge_q == EDGE_S1) smp_d[1] = rx_s;
        end

        unique case (state_q)
            S_IDLE: begin
                edge_d = '0;
                bit_d  = '0;
                if (!rx_s) begin
                    // The detection cycle is edge 0 of the start bit.
                    state_d = S_START;
                    edge_d  = EW'(1);
                    pen_d   = bus.parity_en;
                    ptype_d = bus.parity_type;
                    perr_d  = 1'b0;
                    serr_d  = 1'b0;
                end
            end
            S_START: begin
                if (at_vote && maj) begin
                    state_d = S_IDLE;
                    edge_d  = '0;
                end else if (edge_last) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (at_vote) shift_d = {maj, shift_q[7:1]};
                if (edge_last) begin
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = pen_q ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: begin
                if (at_vote && (maj != (^shift_q ^ ptype_q))) perr_d = 1'b1;
                if (edge_last) state_d = S_STOP;
            end
            S_STOP: begin
                if (at_vote && !maj) serr_d = 1'b1;
                if (edge_last) begin
                    state_d = S_IDLE;
                    pe_d    = perr_d;
                    se_d    = serr_d;
                    if (!perr_d && !serr_d) begin
                        dv_d   = 1'b1;
                        data_d = shift_q;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                edge_d  = '0;
                bit_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            state_q <= S_IDLE;
            edge_q  <= '0;
            bit_q   <= '0;
            smp_q   <= '0;
            shift_q <= '0;
            pen_q   <= 1'b0;
            ptype_q <= 1'b0;
            perr_q  <= 1'b0;
            serr_q  <= 1'b0;
            data_q  <= '0;
            dv_q    <= 1'b0;
            pe_q    <= 1'b0;
            se_q    <= 1'b0;
        end else begin
            sync1_q <= bus.rx_in;
            sync2_q <= sync1_q;
            state_q <= state_d;
            edge_q  <= edge_d;
            bit_q   <= bit_d;
            smp_q   <= smp_d;
            shift_q <= shift_d;
            pen_q   <= pen_d;
            ptype_q <= ptype_d;
            perr_q  <= perr_d;
            serr_q  <= serr_d;
            data_q  <= data_d;
            dv_q    <= dv_d;
            pe_q    <= pe_d;
            se_q    <= se_d;
        end
    end

    assign bus.data_out     = data_q;
    assign bus.data_valid   = dv_q;
    assign bus.parity_error = pe_q;
    assign bus.stop_error   = se_q;
    assign bus.busy         = (state_q != S_IDLE);
endmodule

// File: doc/uart_rx_top.md
Name: uart_rx_top

Overview:
- Receive-side counterpart of the UART transmitter. Consumes the serial line the transmitter drives.
- Recovers 8-bit frames: start bit, 8 data bits LSB first, optional parity bit, one stop bit.
- Oversamples each bit PRESCALE times and takes a 3-sample majority vote at mid-bit.
- Presents each received byte with a one-cycle valid pulse and per-frame error flags.

Parameters:
- PRESCALE, 8, clocks per serial bit; even integer, 4..32.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- rx_in  input  1  serial line; idles high; asynchronous to clk
- parity_en  input  1  1 = frame carries a parity bit
- parity_type  input  1  0 = even parity, 1 = odd parity
- data_out  output  8  last correctly received byte
- data_valid  output  1  one-cycle pulse; data_out updated, frame error-free
- parity_error  output  1  one-cycle pulse; parity mismatch in the frame just ended
- stop_error  output  1  one-cycle pulse; stop bit sampled as 0
- busy  output  1  high while a frame is in progress (state != IDLE)

Behaviour:
- Reset (synchronous, active-high, wins over everything):
  - Two-flop synchronizer on rx_in set to 1.
  - State = IDLE; edge and bit counters = 0.
  - data_out = 0x00; data_valid, parity_error, stop_error, busy = 0.
  - Reset mid-frame abandons the frame; no pulses are generated.
- rx_s is the synchronized rx_in, with 2-cycle latency. All timing below refers to rx_s.
- Edge counter edge_cnt:
  - Counts 0..PRESCALE-1 within each bit, then wraps to 0.
  - The bit counter advances on the wrap.
- Sample points: edge_cnt = PRESCALE/2-1, PRESCALE/2, PRESCALE/2+1.
  - Bit value = majority of the three samples, registered after the third sample.
- States:
  - IDLE:
    - In the cycle rx_s==0 is seen: go to START, count this cycle as edge 0.
    - Latch parity_en and parity_type here; they are held for the whole frame.
  - START:
    - If the majority value is 1 (glitch): go to IDLE immediately after the vote.
    - Otherwise, at edge_cnt==PRESCALE-1, go to DATA.
  - DATA:
    - Shift voted bits in LSB first.
    - After the 8th bit's edge_cnt==PRESCALE-1: go to PARITY if latched parity_en, else to STOP.
  - PARITY:
    - Compute the expected bit: even = XOR of the 8 data bits; odd = its inverse.
    - Record a mismatch.
    - At edge_cnt==PRESCALE-1, go to STOP.
  - STOP:
    - Voted value 0 records a stop error.
    - At edge_cnt==PRESCALE-1, go to IDLE.
- Outputs at frame end (the cycle after STOP's last edge, i.e. the first IDLE cycle):
  - parity_error and stop_error pulse for one cycle if their condition was recorded.
  - data_valid pulses, and data_out loads the shifted byte, only if neither error occurred.
  - On error, data_out holds its previous value.
  - All pulses are registered and last exactly 1 cycle.
- Back-to-back frames:
  - A start bit immediately after a stop bit is detected in the first IDLE cycle.
  - No idle gap is required, and no bits are lost.
- Frame length: 10 bits (11 with parity) × PRESCALE clocks, measured from start detection.
- busy = 1 from START through STOP inclusive.
- Changes on parity_en or parity_type mid-frame have no effect until the next frame.

Test Plan:
- PRESCALE=8, parity off, send 0xA5 → exactly one data_valid pulse, data_out=0xA5, no error pulses. The pulse arrives 2 + 80 cycles after the start falling edge, ±1.
- Parity on, even, send 0x3C with parity bit 0 → data_valid, data_out=0x3C. Repeat with odd type and parity bit 0 → parity_error pulse only, no data_valid, data_out stays 0x3C.
- Send 0x5A with stop bit driven 0 → stop_error pulse, no data_valid, data_out unchanged; the next good frame 0x11 is received correctly.
- Drive rx_in low for 2 cycles, then high → busy pulses briefly, then returns to IDLE; no output pulses; a following frame 0x77 is received correctly.
- Back-to-back frames 0x01 and 0xFF, no idle gap, parity off → two data_valid pulses exactly 80 cycles apart, with data_out=0x01 then 0xFF.
- Assert rst mid-DATA of a frame, then send 0xC3 → no pulses from the aborted frame; busy=0 and data_out=0x00 after reset; 0xC3 received correctly.
